sorting_network_ninputs: RTL
============================

SORTING_NETWORK_NINPUTS -- requirements
Module: sorting_network_ninputs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bit width of each element.
REQ-002 SHALL have parameter N_INPUTS, default 9, number of elements sorted; legal range 2..16.
REQ-003 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port i_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_ce  input  1  clock enable / pipeline advance.
REQ-006 SHALL have port i_valid  input  1  qualifies i_data on an advancing cycle.
REQ-007 SHALL have port i_data  input  N_INPUTS*DATA_WIDTH  packed unsigned elements; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port o_valid  output  1  qualifies all data outputs.
REQ-009 SHALL have port o_sorted  output  N_INPUTS*DATA_WIDTH  elements in ascending order; slot 0 = minimum.
REQ-010 SHALL have port o_min  output  DATA_WIDTH  equals slot 0 of o_sorted.
REQ-011 SHALL have port o_med  output  DATA_WIDTH  equals slot N_INPUTS/2 (integer division) of o_sorted.
REQ-012 SHALL have port o_max  output  DATA_WIDTH  equals slot N_INPUTS-1 of o_sorted.

Function
REQ-013 SHALL implement an odd-even transposition network of exactly N_INPUTS registered stages, stage s = 0..N_INPUTS-1.
REQ-014 SHALL, in even stages, compare-swap pairs (0,1),(2,3),...; in odd stages, pairs (1,2),(3,4),...; an unpaired element passes through registered.
REQ-015 SHALL compare unsigned; on equality, no swap.
REQ-016 SHALL carry a valid bit alongside each stage's data register.
REQ-017 SHALL, when i_ce=1, advance all stage registers and valid bits by one stage per clock.
REQ-018 SHALL, when i_ce=0, hold every data and valid register unchanged; i_valid and i_data are ignored.
REQ-019 SHALL have latency exactly N_INPUTS advancing (i_ce=1) cycles from i_data capture to o_sorted; stalled cycles add no data change.
REQ-020 SHALL accept a new vector on every advancing cycle, giving throughput 1 vector/advance, no bubbles inserted.
REQ-021 SHALL propagate data even when i_valid=0; o_valid=0 marks such outputs as don't-care.
REQ-022 SHALL drive o_sorted, o_min, o_med and o_max directly from last-stage registers, with no combinational path from inputs to outputs.
REQ-023 SHALL keep sort order correct for N_INPUTS odd and even, including N_INPUTS=2 (single compare stage plus one pass stage).

Reset
REQ-024 SHALL, while i_aresetn=0, clear all stage data registers and valid bits to 0 asynchronously; o_valid=0, and o_sorted, o_min, o_med, o_max read 0.
REQ-025 SHALL discard any vectors in flight on reset mid-operation; after release, the first o_valid=1 appears N_INPUTS advancing cycles after the first post-reset i_valid=1.
REQ-026 SHALL resume capture on the first rising edge after i_aresetn deasserts, if i_ce=1.

Verification (N_INPUTS=9, DATA_WIDTH=8)
REQ-027 Scenario: elements {9,8,7,6,5,4,3,2,1} with i_valid=1, i_ce=1 held -> 9 cycles later o_valid=1, o_sorted={1..9} ascending, o_min=1, o_med=5, o_max=9.
REQ-028 Scenario: duplicates {5,5,0,255,5,0,255,5,5} -> o_sorted={0,0,5,5,5,5,5,255,255}, o_med=5.
REQ-029 Scenario: 20 back-to-back random vectors -> 20 consecutive o_valid=1 outputs, each matching a reference sort, in input order.
REQ-030 Scenario: vector issued, then i_ce=0 for 4 cycles at stage 3 -> outputs frozen during stall; result appears after 9 advancing cycles (13 clocks total), o_valid pulses once.
REQ-031 Scenario: i_aresetn pulsed low 2 cycles after 5 valid vectors -> all outputs 0 immediately, o_valid=0; no stale vectors emerge after release.
REQ-032 Scenario: N_INPUTS=2 build, inputs {200,3} -> 2 cycles later o_sorted={3,200}, o_min=3, o_med=200, o_max=200.

Source files
------------

// File: rtl/sorting_network_ninputs.sv
// sorting_network_ninputs
// Pipelined odd-even transposition sorter. N_INPUTS registered stages each
// apply one compare-swap layer (even stages pair (0,1),(2,3)..., odd stages
// pair (1,2),(3,4)...). A valid bit travels with each stage. i_ce advances the
// whole pipeline, and the outputs come straight from the last stage registers.
module sorting_network_ninputs #(
    parameter int DATA_WIDTH = 8,
    parameter int N_INPUTS   = 9
) (
    input  logic                           i_clk,
    input  logic                           i_aresetn,
    input  logic                           i_ce,
    input  logic                           i_valid,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] i_data,
    output logic                           o_valid,
    output logic [N_INPUTS*DATA_WIDTH-1:0] o_sorted,
    output logic [DATA_WIDTH-1:0]          o_min,
    output logic [DATA_WIDTH-1:0]          o_med,
    output logic [DATA_WIDTH-1:0]          o_max
);

    localparam int VEC_W = N_INPUTS * DATA_WIDTH;

    logic [VEC_W-1:0]    data_q [N_INPUTS];
    logic [VEC_W-1:0]    data_d [N_INPUTS];
    logic [N_INPUTS-1:0] valid_q;

    // Next state of every stage: take the previous stage (or the input) and
    // apply this stage's compare-swap layer. Pairs of the other parity are
    // rewritten with their current values, so they pass through unchanged.
    always_comb begin
        logic [DATA_WIDTH-1:0] a_v;
        logic [DATA_WIDTH-1:0] b_v;
        logic                  swap_v;
        a_v    = {DATA_WIDTH{1'b0}};
        b_v    = {DATA_WIDTH{1'b0}};
        swap_v = 1'b0;
        for (int s = 0; s < N_INPUTS; s++) begin
            if (s == 0) begin
                data_d[s] = i_data;
            end else begin
                data_d[s] = data_q[s-1];
            end
            for (int p = 0; p < N_INPUTS - 1; p++) begin
                a_v    = data_d[s][p*DATA_WIDTH +: DATA_WIDTH];
                b_v    = data_d[s][(p+1)*DATA_WIDTH +: DATA_WIDTH];
                // Equal elements never swap.
                swap_v = ((p % 2) == (s % 2)) && (a_v > b_v);
                data_d[s][p*DATA_WIDTH +: DATA_WIDTH]     = swap_v ? b_v : a_v;
                data_d[s][(p+1)*DATA_WIDTH +: DATA_WIDTH] = swap_v ? a_v : b_v;
            end
        end
    end

    // Stage registers and their valid bits: cleared asynchronously, advanced
    // together on i_ce, otherwise held (inputs ignored while stalled).
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int s = 0; s < N_INPUTS; s++) begin
                data_q[s] <= {VEC_W{1'b0}};
            end
            valid_q <= {N_INPUTS{1'b0}};
        end else if (i_ce) begin
            for (int s = 0; s < N_INPUTS; s++) begin
                data_q[s] <= data_d[s];
            end
            valid_q <= {valid_q[N_INPUTS-2:0], i_valid};
        end
    end

    assign o_valid  = valid_q[N_INPUTS-1];
    assign o_sorted = data_q[N_INPUTS-1];
    assign o_min    = data_q[N_INPUTS-1][0 +: DATA_WIDTH];
    assign o_med    = data_q[N_INPUTS-1][(N_INPUTS/2)*DATA_WIDTH +: DATA_WIDTH];
    assign o_max    = data_q[N_INPUTS-1][(N_INPUTS-1)*DATA_WIDTH +: DATA_WIDTH];

endmodule
